finish_detect: RTL

Parametrised, sequential termination detector for WIDTH-bit state vectors. When armed, it watches a stream of sampled vectors and declares completion after HOLD consecutive valid samples that are one-hot on the same bit. It then reports the index of that bit and holds the result until the controller acknowledges it. It sits beside the datapath controller and replaces the fixed 4-bit combinational one-hot check with a debounced, handshaked, width-generic version.

---
 rtl/fd_pkg.sv | 15 +
 rtl/onehot_encode.sv | 34 +++
 rtl/finish_detect.sv | 122 ++++++++++++
 3 files changed

// File: rtl/fd_pkg.sv
// Shared types and helpers for the finish_detect termination detector.
package fd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DONE  = 2'd2
    } fd_state_e;

    // Streak counter must hold values 0..hold inclusive.
    function automatic int streak_width(input int hold);
        return $clog2(hold + 1);
    endfunction

endpackage

// File: rtl/onehot_encode.sv
// Width-generic sample classifier: one-hot / zero flags and lowest set bit index.
module onehot_encode #(
    parameter int WIDTH = 4,
    parameter int IDXW  = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic             is_onehot,
    output logic             is_zero,
    output logic [IDXW-1:0]  idx
);

    // first has only the lowest set bit of vec, so vec is one-hot exactly when it equals first.
    logic [WIDTH-1:0] first;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_first
            localparam logic [WIDTH-1:0] LOW_MASK = (WIDTH'(1) << gi) - WIDTH'(1);
            assign first[gi] = vec[gi] & ~(|(vec & LOW_MASK));
        end
    endgenerate

    assign is_zero   = ~(|vec);
    assign is_onehot = (|vec) && (vec == first);

    always_comb begin
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (first[i]) begin
                idx = idx | IDXW'(i);
            end
        end
    end

endmodule

// File: rtl/finish_detect.sv
// Debounced, handshaked one-hot termination detector for WIDTH-bit state vectors.
module finish_detect
    import fd_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int HOLD  = 2,
    parameter int IDXW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             ack,
    output logic             busy,
    output logic             done,
    output logic [IDXW-1:0]  done_idx,
    output logic             multi_err
);

    localparam int SW = streak_width(HOLD);

    fd_state_e        state_q, state_d;
    logic [SW-1:0]    streak_q, streak_d, streak_upd;
    logic [IDXW-1:0]  last_idx_q, last_idx_d, idx_upd;
    logic [IDXW-1:0]  done_idx_q, done_idx_d;
    logic             done_q, done_d;
    logic             multi_err_q, multi_err_d;

    logic             s_onehot, s_zero;
    logic [IDXW-1:0]  s_idx;

    onehot_encode #(.WIDTH(WIDTH), .IDXW(IDXW)) u_enc (
        .vec       (in_data),
        .is_onehot (s_onehot),
        .is_zero   (s_zero),
        .idx       (s_idx)
    );

    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        last_idx_d  = last_idx_q;
        done_d      = done_q;
        done_idx_d  = done_idx_q;
        multi_err_d = multi_err_q;
        streak_upd  = '0;
        idx_upd     = last_idx_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = ARMED;
                    streak_d    = '0;
                    multi_err_d = 1'b0;
                end
            end
            ARMED: begin
                if (start) begin
                    streak_d    = '0;
                    multi_err_d = 1'b0;
                end else if (in_valid) begin
                    if (s_onehot) begin
                        if (s_idx == last_idx_q && streak_q != '0) begin
                            streak_upd = streak_q + SW'(1);
                        end else begin
                            streak_upd = SW'(1);
                            idx_upd    = s_idx;
                        end
                    end else if (!s_zero) begin
                        multi_err_d = 1'b1;
                    end
                    streak_d   = streak_upd;
                    last_idx_d = idx_upd;
                    if (streak_upd == SW'(HOLD)) begin
                        state_d    = DONE;
                        done_d     = 1'b1;
                        done_idx_d = idx_upd;
                    end
                end
            end
            DONE: begin
                if (ack) begin
                    done_d     = 1'b0;
                    done_idx_d = '0;
                    if (start) begin
                        state_d     = ARMED;
                        streak_d    = '0;
                        multi_err_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            streak_q    <= '0;
            last_idx_q  <= '0;
            done_q      <= 1'b0;
            done_idx_q  <= '0;
            multi_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            last_idx_q  <= last_idx_d;
            done_q      <= done_d;
            done_idx_q  <= done_idx_d;
            multi_err_q <= multi_err_d;
        end
    end

    assign busy      = (state_q == ARMED);
    assign done      = done_q;
    assign done_idx  = done_idx_q;
    assign multi_err = multi_err_q;

endmodule
